// File: rtl/div_sub_desloca_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
// The master issues divisions; the slave (the divider) returns results.
interface div_sub_desloca_if #(
  parameter int N = 4
);
  logic           st;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           v;
  logic           busy;
  logic           done;

  modport master (
    output st, dividend, divisor,
    input  quotient, remainder, v, busy, done
  );

  modport slave (
    input  st, dividend, divisor,
    output quotient, remainder, v, busy, done
  );
endinterface

// File: rtl/div_sub_desloca.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Optional macro DIV_STICKY_DONE_EN keeps done high until the next accepted start.
module div_sub_desloca #(
  parameter int N = 4
) (
  input logic              clk,
  input logic              rst,
  div_sub_desloca_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CHK, ITER, DONE} state_t;

  state_t        state;
  logic [2*N:0]  a;
  logic [N-1:0]  d;
  logic [CW-1:0] cnt;
  logic          v_q;
  logic          busy_q;
  logic          done_q;

  // Shifted working register and trial subtraction for the current iteration.
  logic [2*N:0] t;
  logic [N:0]   diff;

  assign t    = {a[2*N-1:0], 1'b0};
  assign diff = t[2*N:N] - {1'b0, d};

  assign bus.quotient  = a[N-1:0];
  assign bus.remainder = a[2*N-1:N];
  assign bus.v         = v_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a      <= '0;
      d      <= '0;
      cnt    <= '0;
      v_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.st) begin
            a      <= {1'b0, bus.dividend};
            d      <= bus.divisor;
            v_q    <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            state  <= CHK;
          end
        end
        CHK: begin
          // Upper half >= divisor means the quotient cannot fit; also catches d == 0.
          if (a[2*N:N] >= {1'b0, d}) begin
            v_q    <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            state <= ITER;
          end
        end
        ITER: begin
          if (t[2*N:N] >= {1'b0, d}) begin
            a <= {diff, t[N-1:1], 1'b1};
          end else begin
            a <= t;
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
`ifndef DIV_STICKY_DONE_EN
          done_q <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_sub_desloca.sv
// Self-checking bench for div_sub_desloca (N=4): directed cases plus random
// operands checked against plain integer division.
module tb_div_sub_desloca;
  localparam int N = 4;
`ifdef DIV_STICKY_DONE_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  div_sub_desloca_if #(.N(N)) bus ();

  div_sub_desloca #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: unsigned integer division with overflow when the quotient exceeds N bits.
  task automatic model(input int dd, input int dv, output int q, output int r, output bit ov);
    q  = 0;
    r  = 0;
    ov = 1'b1;
    if (dv != 0) begin
      q  = dd / dv;
      r  = dd % dv;
      ov = (q > (2 ** N) - 1);
    end
  endtask

  // Starts a division and checks latency and results. When poke > 0 an extra
  // start with junk operands is driven while the divider is busy.
  task automatic run_div(input int dd, input int dv, input int poke);
    int q, r, lat;
    bit ov;
    model(dd, dv, q, r, ov);
    bus.st       = 1'b1;
    bus.dividend = (2*N)'(dd);
    bus.divisor  = N'(dv);
    @(posedge clk); #1;
    bus.st       = 1'b0;
    bus.dividend = (2*N)'($urandom);
    bus.divisor  = N'($urandom);
    check("busy_after_start", 32'(bus.busy), 1);
    check("done_after_start", 32'(bus.done), 0);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 20) begin
      bus.st = (lat == poke);
      if (lat == poke) begin
        bus.dividend = (2*N)'($urandom);
        bus.divisor  = N'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.st = 1'b0;
    check("latency", 32'(lat), ov ? 2 : N + 2);
    check("v", 32'(bus.v), 32'(ov));
    check("busy_at_done", 32'(bus.busy), 0);
    if (!ov) begin
      check("quotient", 32'(bus.quotient), 32'(q));
      check("remainder", 32'(bus.remainder), 32'(r));
    end
    @(posedge clk); #1;
    check("done_after_pulse", 32'(bus.done), 32'(STICKY));
    check("busy_idle", 32'(bus.busy), 0);
    if (!ov) check("quotient_hold", 32'(bus.quotient), 32'(q));
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.st       = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_quotient", 32'(bus.quotient), 0);
    check("reset_remainder", 32'(bus.remainder), 0);
    check("reset_v", 32'(bus.v), 0);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_done", 32'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_div(135, 13, 0);
    run_div(100, 7, 0);
    // Extended idle after 100/7: done stays or stays low depending on the build
    repeat (5) begin
      @(posedge clk); #1;
      check("done_idle", 32'(bus.done), 32'(STICKY));
      check("remainder_idle", 32'(bus.remainder), 2);
    end
    run_div(208, 13, 0);
    run_div(8'h5A, 0, 0);
    run_div(0, 5, 0);
    run_div(119, 15, 0);
    run_div(255, 15, 0);
    run_div(239, 15, 0);

    // Start request while busy must be ignored
    run_div(135, 13, 3);

    // Asynchronous reset mid-division
    bus.st       = 1'b1;
    bus.dividend = 8'd135;
    bus.divisor  = 4'd13;
    @(posedge clk); #1;
    bus.st = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    check("arst_quotient", 32'(bus.quotient), 0);
    check("arst_remainder", 32'(bus.remainder), 0);
    check("arst_v", 32'(bus.v), 0);
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_done", 32'(bus.done), 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("arst_no_done", 32'(bus.done), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_div(119, 15, 0);

    // Random operands, roughly half chosen to avoid overflow
    for (int i = 0; i < 40; i++) begin
      int dv, dd;
      dv = $urandom_range(0, 15);
      if (i % 2 == 0 && dv != 0) dd = $urandom_range(0, dv * 16 - 1);
      else dd = $urandom_range(0, 255);
      run_div(dd, dv, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
